// File: rtl/branch_predictor_btb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// branch_predictor_btb : direct-mapped BTB with saturating direction counters,
//                        EX-stage mispredict/redirect and performance counters
// Revision: 1.0
// ----------------------------------------------------------------------------
module branch_predictor_btb #(
   parameter int ADDR_WIDTH = 32,
   parameter int ENTRIES    = 16,
   parameter int CTR_BITS   = 2,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] if_pc,
   output logic                  pred_taken,
   output logic [ADDR_WIDTH-1:0] pred_target,
   input  logic                  ex_valid,
   input  logic                  ex_branch,
   input  logic                  ex_jump,
   input  logic [ADDR_WIDTH-1:0] ex_pc,
   input  logic                  ex_taken,
   input  logic [ADDR_WIDTH-1:0] ex_target,
   input  logic                  ex_pred_taken,
   input  logic [ADDR_WIDTH-1:0] ex_pred_target,
   input  logic                  btb_clear,
   output logic                  mispredict,
   output logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  flush,
   output logic [CNT_WIDTH-1:0]  branch_count,
   output logic [CNT_WIDTH-1:0]  mispredict_count
);

   localparam int IDX_BITS = $clog2(ENTRIES);
   localparam int TAG_W    = ADDR_WIDTH - IDX_BITS - 2;
   localparam logic [CTR_BITS-1:0]   CTR_WEAK = CTR_BITS'(1 << (CTR_BITS - 1));
   localparam logic [CTR_BITS-1:0]   CTR_MAX  = '1;
   localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;
   localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(4);

   logic                  valid_q  [ENTRIES];
   logic [TAG_W-1:0]      tag_q    [ENTRIES];
   logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
   logic [CTR_BITS-1:0]   ctr_q    [ENTRIES];
   logic                  jump_q   [ENTRIES];

   logic [CNT_WIDTH-1:0]  bcnt_q, bcnt_d;
   logic [CNT_WIDTH-1:0]  mcnt_q, mcnt_d;

   // Fetch-side read port
   logic [IDX_BITS-1:0]   if_idx;
   logic [TAG_W-1:0]      if_tag;
   logic                  if_hit;

   assign if_idx      = if_pc[IDX_BITS+1:2];
   assign if_tag      = if_pc[ADDR_WIDTH-1:IDX_BITS+2];
   assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
   assign pred_taken  = if_hit && (jump_q[if_idx] || ctr_q[if_idx][CTR_BITS-1]);
   assign pred_target = pred_taken ? target_q[if_idx] : if_pc + PC_STEP;

   // Resolution
   logic res;
   assign res         = ex_valid && (ex_branch || ex_jump);
   assign mispredict  = res && ((ex_taken != ex_pred_taken) ||
                                (ex_taken && (ex_target != ex_pred_target)));
   assign flush       = mispredict;
   assign redirect_pc = ex_taken ? ex_target : ex_pc + PC_STEP;

   // Training-side read port
   logic [IDX_BITS-1:0]   ex_idx;
   logic [TAG_W-1:0]      ex_tag;
   logic                  ex_hit;
   logic [CTR_BITS-1:0]   ex_ctr;
   logic [CTR_BITS-1:0]   ctr_d;
   logic [ADDR_WIDTH-1:0] target_d;
   logic                  jump_d;
   logic                  wr_en;

   assign ex_idx = ex_pc[IDX_BITS+1:2];
   assign ex_tag = ex_pc[ADDR_WIDTH-1:IDX_BITS+2];
   assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
   assign ex_ctr = ctr_q[ex_idx];
   assign wr_en  = res && !btb_clear && (ex_hit || ex_taken);

   always_comb begin
      ctr_d    = CTR_WEAK;
      target_d = target_q[ex_idx];
      jump_d   = jump_q[ex_idx];
      if (ex_hit) begin
         if (ex_taken)
            ctr_d = (ex_ctr == CTR_MAX) ? ex_ctr : ex_ctr + CTR_BITS'(1);
         else
            ctr_d = (ex_ctr == '0) ? ex_ctr : ex_ctr - CTR_BITS'(1);
      end
      if (ex_taken) begin
         target_d = ex_target;
         jump_d   = ex_jump;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= '0;
            jump_q[i]   <= 1'b0;
         end
      end else if (btb_clear) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
         end
      end else if (wr_en) begin
         valid_q[ex_idx]  <= 1'b1;
         tag_q[ex_idx]    <= ex_tag;
         target_q[ex_idx] <= target_d;
         ctr_q[ex_idx]    <= ctr_d;
         jump_q[ex_idx]   <= jump_d;
      end
   end

   // Performance counters saturate and are unaffected by btb_clear
   assign bcnt_d = (res && (bcnt_q != CNT_MAX)) ? bcnt_q + CNT_WIDTH'(1) : bcnt_q;
   assign mcnt_d = (mispredict && (mcnt_q != CNT_MAX)) ? mcnt_q + CNT_WIDTH'(1) : mcnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcnt_q <= '0;
         mcnt_q <= '0;
      end else begin
         bcnt_q <= bcnt_d;
         mcnt_q <= mcnt_d;
      end
   end

   assign branch_count     = bcnt_q;
   assign mispredict_count = mcnt_q;

   logic unused_pc_lsbs;
   assign unused_pc_lsbs = ^{if_pc[1:0], ex_pc[1:0]};

endmodule
`default_nettype wire

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
- Parametrised successor to the EX-stage branch/jump control unit. Adds dynamic prediction: a direct-mapped branch target buffer (BTB) with per-entry saturating direction counters.
- IF stage looks up the fetch PC and gets a predicted next PC in the same cycle.
- EX stage feeds back the resolved outcome. The block detects mispredictions, generates redirect PC and flush, and trains the table.
- Also keeps saturating performance counters for branches and mispredictions.

Parameters:
- ADDR_WIDTH, 32, PC/target width.
- ENTRIES, 16, BTB entries; power of 2, range 2..256. IDX_BITS = log2(ENTRIES).
- CTR_BITS, 2, direction counter width, range 1..4. Taken when counter MSB = 1.
- CNT_WIDTH, 32, performance counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_pc  in  ADDR_WIDTH  fetch PC to look up.
- pred_taken  out  1  predicted taken for if_pc.
- pred_target  out  ADDR_WIDTH  predicted next PC.
- ex_valid  in  1  EX-stage instruction valid (not a bubble).
- ex_branch  in  1  EX instruction is a B-type branch.
- ex_jump  in  1  EX instruction is JAL/JALR.
- ex_pc  in  ADDR_WIDTH  PC of EX instruction.
- ex_taken  in  1  resolved outcome from branch/jump condition logic.
- ex_target  in  ADDR_WIDTH  resolved target address.
- ex_pred_taken  in  1  prediction carried down the pipeline with the instruction.
- ex_pred_target  in  ADDR_WIDTH  predicted next PC carried down the pipeline.
- btb_clear  in  1  synchronous invalidate of all entries (fence.i / context switch).
- mispredict  out  1  EX resolution disagrees with prediction.
- redirect_pc  out  ADDR_WIDTH  correct next PC when mispredict = 1.
- flush  out  1  clear IF/ID and ID/EX; equals mispredict.
- branch_count  out  CNT_WIDTH  resolved branches + jumps.
- mispredict_count  out  CNT_WIDTH  mispredictions.

Behaviour:
- Entry fields: valid, tag = pc[ADDR_WIDTH-1:IDX_BITS+2], target, ctr[CTR_BITS-1:0], is_jump. Index = pc[IDX_BITS+1:2]. pc[1:0] ignored.
- Reset (async, rst_n = 0):
  - all valid = 0, ctr = 0, counters = 0.
  - Outputs are combinational: pred_taken = 0, pred_target = if_pc + 4, mispredict = flush = 0 while ex_valid = 0.
- Lookup (combinational, zero latency):
  - hit = valid & tag match.
  - pred_taken = hit & (is_jump | ctr[MSB]).
  - pred_target = pred_taken ? target : if_pc + 4 (modulo 2^ADDR_WIDTH).
- Resolve (combinational). Let res = ex_valid & (ex_branch | ex_jump).
  - Condition A: ex_taken != ex_pred_taken.
  - Condition B: ex_taken & (ex_target != ex_pred_target).
  - mispredict = res & (A | B).
  - redirect_pc = ex_taken ? ex_target : ex_pc + 4.
  - flush = mispredict.
  - ex_branch and ex_jump both set: treat as jump.
- Training (on clock edge when res = 1). The table is re-read at ex_pc through a second read port.
  - Hit, taken: ctr saturating increment, target <= ex_target, is_jump <= ex_jump.
  - Hit, not taken: ctr saturating decrement (floor 0), target unchanged.
  - Miss, taken: allocate/overwrite. valid = 1, tag, target = ex_target, ctr = 2^(CTR_BITS-1) (weakly taken), is_jump = ex_jump.
  - Miss, not taken: no change.
  - CTR_BITS = 1: increment sets 1, decrement clears to 0.
- Same cycle lookup and update at the same index: lookup returns pre-update contents; the write is visible next cycle.
- btb_clear and res in the same cycle: clear wins. All valid = 0, no allocation that cycle. Counters still update.
- Performance counters:
  - branch_count += 1 when res = 1.
  - mispredict_count += 1 when mispredict = 1.
  - Both saturate at 2^CNT_WIDTH - 1. btb_clear does not reset them.
- Reset asserted mid-operation: immediate return to reset state. No partial entry writes survive.
- Target: 120–300 lines RTL. Storage is register arrays, not a macro.

Test Plan:
- Reset, then if_pc = 0x100 -> pred_taken = 0, pred_target = 0x104. ex_valid = 0 -> mispredict = 0, both counters = 0.
- Taken BEQ, ex_pc = 0x100, ex_target = 0x80, ex_pred_taken = 0 -> mispredict = 1, redirect_pc = 0x80. Next cycle if_pc = 0x100 gives pred_taken = 1, pred_target = 0x80 (ctr = 2).
- Same branch resolved not-taken twice, ex_pred_taken matching the prediction each time:
  - first -> mispredict = 1, redirect 0x104, ctr 2→1.
  - second -> mispredict = 0, ctr 1→0, pred_taken = 0.
  - mispredict_count = 2.
- Aliasing: taken JAL at 0x100 then taken JAL at 0x100 + 4*ENTRIES (0x140) -> entry overwritten. Lookup 0x100 misses (pred_target = 0x104); lookup 0x140 hits, pred_taken = 1.
- JALR hit with stale target: ex_pred_target = 0x200, ex_target = 0x300, both taken -> mispredict = 1, redirect_pc = 0x300, stored target becomes 0x300.
- btb_clear with a simultaneous taken miss -> no entries valid next cycle, branch_count increments.
- rst_n dropped mid-run -> counters = 0, pred_taken = 0 immediately.
